instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Producer side of the decode interface: owns the program counter and issues word reads to instruction memory.
- Returns one {PC, Instruction} pair per handshake to the downstream decoder, which slices opcode and register fields out of Instruction.
- Single outstanding memory request; branch redirect with discard of stale responses; stall support.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (low two bits must be zero).
- NOP_WORD, 32'h0000_0013, value driven on Instruction while no valid instruction is held.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  downstream hold; blocks the handshake while high.
- Branch_Taken  input  1  redirect request, one-cycle pulse.
- Branch_Target  input  32  redirect address.
- Mem_Req  output  1  read request valid.
- Mem_Addr  output  32  word-aligned read address.
- Mem_Ready  input  1  memory accepts the request this cycle.
- Mem_Rvalid  input  1  read data valid.
- Mem_Rdata  input  32  read data.
- PC  output  32  address of the held instruction.
- Instruction  output  32  held instruction word.
- Instr_Valid  output  1  PC/Instruction are valid.
- Instr_Ready  input  1  decoder accepts.
- Fetch_Misaligned  output  1  one-cycle pulse: Branch_Target[1:0] was nonzero.
- Fetch_Count  output  32  count of delivered instructions.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=REQ, fetch_pc=RESET_PC, PC=RESET_PC, Instruction=NOP_WORD.
  - Instr_Valid=0, Mem_Req=0 during the reset cycle, discard=0, Fetch_Misaligned=0, Fetch_Count=0.
  - Reset mid-transaction abandons the in-flight read; a later Mem_Rvalid is ignored unless state=WAIT.
- Mem_Req=1 only in REQ; Mem_Addr=fetch_pc, stable while Mem_Req=1 and Mem_Ready=0.
- State REQ:
  - On Mem_Ready: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go to WAIT.
  - Addition is modulo 2^32 (0xFFFF_FFFC wraps to 0).
- State WAIT:
  - Mem_Rvalid with discard=1: drop the data, discard<=0, go to REQ.
  - Mem_Rvalid with discard=0: Instruction<=Mem_Rdata, PC<=inflight_pc, Instr_Valid<=1, go to HOLD.
- State HOLD:
  - Handshake when Instr_Valid & Instr_Ready & ~Stall: Instr_Valid<=0, Instruction<=NOP_WORD, Fetch_Count<=Fetch_Count+1 (wraps), go to REQ.
  - Stall=1 freezes PC, Instruction and Instr_Valid regardless of Instr_Ready.
- Latency: Mem_Ready edge to Instr_Valid = memory latency + 1 cycle. Minimum 3 cycles per instruction with zero-wait memory.
- Redirect (Branch_Taken=1) has priority over all non-reset events:
  - fetch_pc<={Branch_Target[31:2],2'b00}.
  - Fetch_Misaligned<=|Branch_Target[1:0] for one cycle.
  - Instr_Valid<=0; a handshake in the same cycle does not count.
- Redirect action per state:
  - REQ without Mem_Ready: stay in REQ; next request uses the target.
  - REQ with Mem_Ready the same cycle: request for the old address is accepted; go to WAIT with discard<=1.
  - WAIT without Mem_Rvalid: discard<=1, stay in WAIT.
  - WAIT with Mem_Rvalid the same cycle: drop the data, go to REQ, discard<=0.
  - HOLD: go to REQ.
- Mem_Rvalid outside WAIT is ignored.
- Stall in REQ or WAIT does not block memory traffic; it only blocks the HOLD handshake.

Decomposition:
- Shared package holds:
  - State enum {REQ, WAIT, HOLD} (2-bit).
  - NOP_WORD and RESET_PC defaults.
  - Word-increment constant 32'd4.
- No sub-module needed. The PC/redirect update logic may optionally be split into instruction_fetch_pc (fetch_pc register plus next-pc mux).

Test Plan:
- Reset, zero-wait memory (Mem_Ready=1, Mem_Rvalid one cycle after request), Instr_Ready=1 -> PC sequence 0,4,8 delivered; Instr_Valid once every 3 cycles; Fetch_Count=3.
- Memory returns 0x00A28293 for address 0 with Stall=1 for 5 cycles -> PC=0, Instruction=0x00A28293 held; Instr_Valid=1 all 5 cycles; Fetch_Count unchanged; advances one cycle after Stall drops.
- Branch_Taken with Branch_Target=0x100 while in WAIT, old response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never shown; next request Mem_Addr=0x100; delivered PC=0x100.
- Branch_Target=0x203 in HOLD -> Fetch_Misaligned pulses 1 cycle; Instr_Valid drops; next Mem_Addr=0x200.
- RESET_PC=0xFFFF_FFFC -> first fetch 0xFFFF_FFFC, second Mem_Addr=0x0000_0000.
- Reset asserted in WAIT, then stray Mem_Rvalid -> outputs at reset values; Mem_Req reasserts at RESET_PC the cycle after reset drops; stray data not delivered.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_fetch_pkg;

    // Fetch FSM state encoding
    typedef logic [1:0] fetch_state_t;
    localparam logic [1:0] ST_REQ  = 2'd0;   // issuing a read request
    localparam logic [1:0] ST_WAIT = 2'd1;   // request accepted, awaiting data
    localparam logic [1:0] ST_HOLD = 2'd2;   // instruction presented to decoder

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] WORD_INCR        = 32'd4;

    // Sequential word address; wraps modulo 2^32
    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + WORD_INCR;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// Fetch address register with redirect / sequential-advance mux.
// Latency: new address visible the cycle after redirect or advance.
// Backpressure: none; advances only when the parent reports an accepted request.
module instruction_fetch_pc
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        core_clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        redirect,
    input  logic [29:0] target_word,
    output logic [31:0] fetch_pc
);

    logic [31:0] next_pc;

    // Redirect outranks sequential advance; target is forced word-aligned
    always_comb begin
        next_pc = fetch_pc;
        if (redirect) begin
            next_pc = {target_word, 2'b00};
        end else if (advance) begin
            next_pc = next_word(fetch_pc);
        end
    end

    // Fetch address register
    always_ff @(posedge core_clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else begin
            fetch_pc <= next_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding word read, delivers {PC, Instruction} to decode.
// Latency: Mem_Ready edge to Instr_Valid = memory latency + 1; >= 3 cycles per instruction.
// Backpressure: Stall or ~Instr_Ready holds the instruction; memory traffic is never stalled.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
)
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ready,
    input  logic        Mem_Rvalid,
    input  logic [31:0] Mem_Rdata,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        Instr_Valid,
    input  logic        Instr_Ready,
    output logic        Fetch_Misaligned,
    output logic [31:0] Fetch_Count
);

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        discard;
    logic        mem_accept;
    logic        handshake;

    // Request is held low through the reset cycle itself
    assign Mem_Req    = (state == ST_REQ) && !Reset;
    assign Mem_Addr   = fetch_pc;
    assign mem_accept = Mem_Req && Mem_Ready;
    assign handshake  = (state == ST_HOLD) && Instr_Valid && Instr_Ready && !Stall;

    instruction_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .core_clk    (Clock),
        .reset       (Reset),
        .advance     (mem_accept),
        .redirect    (Branch_Taken),
        .target_word (Branch_Target[31:2]),
        .fetch_pc    (fetch_pc)
    );

    // Fetch FSM, output holding registers and delivered-instruction counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state            <= ST_REQ;
            inflight_pc      <= RESET_PC;
            discard          <= 1'b0;
            PC               <= RESET_PC;
            Instruction      <= NOP_WORD;
            Instr_Valid      <= 1'b0;
            Fetch_Misaligned <= 1'b0;
            Fetch_Count      <= 32'd0;
        end else begin
            Fetch_Misaligned <= Branch_Taken && (Branch_Target[1:0] != 2'b00);
            case (state)
                ST_REQ: begin
                    if (Mem_Ready) begin
                        // A redirect in the accept cycle still launches the old
                        // address, so its response must be thrown away.
                        inflight_pc <= fetch_pc;
                        discard     <= Branch_Taken;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (Mem_Rvalid) begin
                        if (discard || Branch_Taken) begin
                            discard <= 1'b0;
                            state   <= ST_REQ;
                        end else begin
                            Instruction <= Mem_Rdata;
                            PC          <= inflight_pc;
                            Instr_Valid <= 1'b1;
                            state       <= ST_HOLD;
                        end
                    end else if (Branch_Taken) begin
                        discard <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (Branch_Taken) begin
                        // Redirect kills the held instruction; a coincident
                        // handshake is not counted.
                        Instr_Valid <= 1'b0;
                        Instruction <= NOP_WORD;
                        state       <= ST_REQ;
                    end else if (handshake) begin
                        Instr_Valid <= 1'b0;
                        Instruction <= NOP_WORD;
                        Fetch_Count <= Fetch_Count + 32'd1;
                        state       <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D0  = 32'h00A2_8293;

    logic        Clock;
    logic        Reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ready;
    logic        Mem_Rvalid;
    logic [31:0] Mem_Rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic        Fetch_Misaligned;
    logic [31:0] Fetch_Count;

    // Second instance exercising address wrap from the top of memory
    logic        w_reset;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_pc;
    logic [31:0] w_ins;
    logic        w_vld;
    logic        w_mis;
    logic [31:0] w_cnt;
    logic        w_stall;
    logic        w_br;
    logic [31:0] w_tgt;
    logic        w_ready;
    logic        w_ird;

    logic auto_mem;
    int   total;
    int   bad;

    instruction_fetch dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Stall            (Stall),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .Mem_Req          (Mem_Req),
        .Mem_Addr         (Mem_Addr),
        .Mem_Ready        (Mem_Ready),
        .Mem_Rvalid       (Mem_Rvalid),
        .Mem_Rdata        (Mem_Rdata),
        .PC               (PC),
        .Instruction      (Instruction),
        .Instr_Valid      (Instr_Valid),
        .Instr_Ready      (Instr_Ready),
        .Fetch_Misaligned (Fetch_Misaligned),
        .Fetch_Count      (Fetch_Count)
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .Clock            (Clock),
        .Reset            (w_reset),
        .Stall            (w_stall),
        .Branch_Taken     (w_br),
        .Branch_Target    (w_tgt),
        .Mem_Req          (w_req),
        .Mem_Addr         (w_addr),
        .Mem_Ready        (w_ready),
        .Mem_Rvalid       (w_rvalid),
        .Mem_Rdata        (w_rdata),
        .PC               (w_pc),
        .Instruction      (w_ins),
        .Instr_Valid      (w_vld),
        .Instr_Ready      (w_ird),
        .Fetch_Misaligned (w_mis),
        .Fetch_Count      (w_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ird;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic [31:0] eins;
        logic [31:0] ecnt;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    // Contents of the behavioural instruction memory
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? D0 : (a + 32'h1000_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock; in auto mode answer an accepted request one cycle later
    task automatic cycle();
        logic        acc;
        logic        wacc;
        logic [31:0] a;
        @(negedge Clock);
        acc  = Mem_Req && Mem_Ready;
        a    = Mem_Addr;
        wacc = w_req && w_ready;
        @(posedge Clock);
        #1;
        if (auto_mem) begin
            Mem_Rvalid = acc;
            Mem_Rdata  = mem_word(a);
        end
        w_rvalid = wacc;
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic r,
                       input logic q, input logic [31:0] ad, input logic v, input logic [31:0] p,
                       input logic [31:0] ins, input logic [31:0] c, input logic m);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.ird = r;
        x.ereq = q; x.eaddr = ad; x.evld = v; x.epc = p; x.eins = ins; x.ecnt = c; x.emis = m;
        vecs.push_back(x);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0;
        Mem_Ready = 1'b1; Mem_Rvalid = 1'b0; Mem_Rdata = 32'h0; Instr_Ready = 1'b1;
        auto_mem = 1'b1;
        w_reset = 1'b1; w_rvalid = 1'b0; w_rdata = 32'h0000_0517; w_stall = 1'b0;
        w_br = 1'b0; w_tgt = 32'h0; w_ready = 1'b1; w_ird = 1'b1;

        // Reset state
        cycle();
        cycle();
        chk("rst.req", {31'h0, Mem_Req}, 32'h0);
        chk("rst.vld", {31'h0, Instr_Valid}, 32'h0);
        chk("rst.pc", PC, 32'h0);
        chk("rst.ins", Instruction, NOP);
        chk("rst.cnt", Fetch_Count, 32'h0);
        chk("rst.mis", {31'h0, Fetch_Misaligned}, 32'h0);
        Reset = 1'b0;

        // stall br tgt ird | req addr vld pc ins cnt mis
        add(0, 0, 0, 1,  0, 32'h4,   0, 32'h0,   NOP,           0, 0);
        add(0, 0, 0, 1,  0, 32'h4,   1, 32'h0,   D0,            0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 0, 0, 1,  0, 32'h4, 1, 32'h0, D0,            0, 0);
        add(0, 0, 0, 1,  1, 32'h4,   0, 32'h0,   NOP,           1, 0);
        add(0, 0, 0, 1,  0, 32'h8,   0, 32'h0,   NOP,           1, 0);
        add(0, 0, 0, 1,  0, 32'h8,   1, 32'h4,   32'h1000_0004, 1, 0);
        add(0, 0, 0, 1,  1, 32'h8,   0, 32'h4,   NOP,           2, 0);
        add(0, 0, 0, 1,  0, 32'hC,   0, 32'h4,   NOP,           2, 0);
        add(0, 0, 0, 1,  0, 32'hC,   1, 32'h8,   32'h1000_0008, 2, 0);
        add(0, 0, 0, 0,  0, 32'hC,   1, 32'h8,   32'h1000_0008, 2, 0);
        add(0, 0, 0, 1,  1, 32'hC,   0, 32'h8,   NOP,           3, 0);
        add(0, 0, 0, 1,  0, 32'h10,  0, 32'h8,   NOP,           3, 0);
        add(0, 0, 0, 1,  0, 32'h10,  1, 32'hC,   32'h1000_000C, 3, 0);
        add(0, 1, 32'h203, 1, 1, 32'h200, 0, 32'hC, NOP,        3, 1);
        add(0, 0, 0, 1,  0, 32'h204, 0, 32'hC,   NOP,           3, 0);
        add(0, 0, 0, 1,  0, 32'h204, 1, 32'h200, 32'h1000_0200, 3, 0);
        add(0, 0, 0, 1,  1, 32'h204, 0, 32'h200, NOP,           4, 0);

        foreach (vecs[i]) begin
            Stall         = vecs[i].stall;
            Branch_Taken  = vecs[i].br;
            Branch_Target = vecs[i].tgt;
            Instr_Ready   = vecs[i].ird;
            cycle();
            chk($sformatf("v%0d.req", i),  {31'h0, Mem_Req}, {31'h0, vecs[i].ereq});
            chk($sformatf("v%0d.addr", i), Mem_Addr, vecs[i].eaddr);
            chk($sformatf("v%0d.vld", i),  {31'h0, Instr_Valid}, {31'h0, vecs[i].evld});
            chk($sformatf("v%0d.pc", i),   PC, vecs[i].epc);
            chk($sformatf("v%0d.ins", i),  Instruction, vecs[i].eins);
            chk($sformatf("v%0d.cnt", i),  Fetch_Count, vecs[i].ecnt);
            chk($sformatf("v%0d.mis", i),  {31'h0, Fetch_Misaligned}, {31'h0, vecs[i].emis});
        end
        Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0; Instr_Ready = 1'b1;

        // Redirect while waiting: stale 0xDEADBEEF must be dropped
        auto_mem = 1'b0; Mem_Rvalid = 1'b0; Mem_Ready = 1'b1;
        cycle();                                     // accept 0x204
        Mem_Ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h100;
        cycle();
        chk("br.req", {31'h0, Mem_Req}, 32'h0);
        chk("br.addr", Mem_Addr, 32'h100);
        Branch_Taken = 1'b0; Branch_Target = 32'h0;
        cycle();
        Mem_Rvalid = 1'b1; Mem_Rdata = 32'hDEAD_BEEF;
        cycle();
        chk("stale.vld", {31'h0, Instr_Valid}, 32'h0);
        chk("stale.ins", Instruction, NOP);
        chk("stale.req", {31'h0, Mem_Req}, 32'h1);
        chk("stale.addr", Mem_Addr, 32'h100);
        Mem_Rvalid = 1'b0; Mem_Ready = 1'b1;
        cycle();                                     // accept 0x100
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h1234_5678;
        cycle();
        chk("tgt.vld", {31'h0, Instr_Valid}, 32'h1);
        chk("tgt.pc", PC, 32'h100);
        chk("tgt.ins", Instruction, 32'h1234_5678);
        Mem_Rvalid = 1'b0;
        cycle();
        chk("tgt.cnt", Fetch_Count, 32'd5);
        chk("tgt.next", Mem_Addr, 32'h104);

        // Reset in WAIT followed by a stray response
        Mem_Ready = 1'b1;
        cycle();                                     // accept 0x104
        Reset = 1'b1; Mem_Ready = 1'b0;
        cycle();
        chk("rw.req", {31'h0, Mem_Req}, 32'h0);
        chk("rw.vld", {31'h0, Instr_Valid}, 32'h0);
        chk("rw.pc", PC, 32'h0);
        chk("rw.cnt", Fetch_Count, 32'h0);
        Reset = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'hBAD0_BAD0;
        cycle();
        chk("stray.req", {31'h0, Mem_Req}, 32'h1);
        chk("stray.addr", Mem_Addr, 32'h0);
        chk("stray.vld", {31'h0, Instr_Valid}, 32'h0);
        chk("stray.ins", Instruction, NOP);
        Mem_Rvalid = 1'b0; Mem_Ready = 1'b1;
        cycle();                                     // accept 0x0
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = D0;
        cycle();
        chk("rr.vld", {31'h0, Instr_Valid}, 32'h1);
        chk("rr.pc", PC, 32'h0);
        chk("rr.ins", Instruction, D0);
        Mem_Rvalid = 1'b0;

        // Wrap-around fetch address from RESET_PC = 0xFFFF_FFFC
        w_reset = 1'b0;
        #1;
        chk("wrap.req0", {31'h0, w_req}, 32'h1);
        chk("wrap.addr0", w_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap.addr1", w_addr, 32'h0);
        cycle();
        chk("wrap.vld", {31'h0, w_vld}, 32'h1);
        chk("wrap.pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap.ins", w_ins, 32'h0000_0517);
        cycle();
        chk("wrap.req1", {31'h0, w_req}, 32'h1);
        chk("wrap.addr2", w_addr, 32'h0);
        chk("wrap.cnt", w_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
